// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   ID/EX issue stage feeding the ALU. Decodes opcode/funct3/funct7 into a
//   4-bit ALU operation, selects operands A/B and presents them under a
//   valid/ready handshake. A one-entry skid buffer behind the main output
//   register absorbs back-pressure without losing or reordering beats.
//
// Ports
//   clk, reset             rising-edge clock, asynchronous active-low reset
//   Opcode_i/Funct3_i/Funct7_i  instruction fields to decode
//   Rd_i                   destination index carried with the beat
//   Rs1_Data_i/Rs2_Data_i  register-file read data
//   Imm_i                  sign-extended immediate (LUI: instr[31:12] in [19:0])
//   In_Valid_i/In_Ready_o  upstream handshake
//   Flush_i                synchronous kill of all held beats
//   ALU_Operation_o, A_o, B_o, Rd_o, Illegal_o  registered output beat
//   Out_Valid_o/Out_Ready_i  downstream handshake
//   Issued_Count_o         wrapping count of output transfers
module alu_issue_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            Opcode_i,
  input  logic [2:0]            Funct3_i,
  input  logic [6:0]            Funct7_i,
  input  logic [4:0]            Rd_i,
  input  logic [DATA_WIDTH-1:0] Rs1_Data_i,
  input  logic [DATA_WIDTH-1:0] Rs2_Data_i,
  input  logic [DATA_WIDTH-1:0] Imm_i,
  input  logic                  In_Valid_i,
  output logic                  In_Ready_o,
  input  logic                  Flush_i,
  output logic [3:0]            ALU_Operation_o,
  output logic [DATA_WIDTH-1:0] A_o,
  output logic [DATA_WIDTH-1:0] B_o,
  output logic [4:0]            Rd_o,
  output logic                  Illegal_o,
  output logic                  Out_Valid_o,
  input  logic                  Out_Ready_i,
  output logic [CNT_WIDTH-1:0]  Issued_Count_o
);

  typedef enum logic [3:0] {
    ALU_ADD     = 4'b0000,
    ALU_LUI     = 4'b0001,
    ALU_ORI     = 4'b0010,
    ALU_SLLI    = 4'b0011,
    ALU_SRLI    = 4'b0100,
    ALU_SUB     = 4'b0101,
    ALU_ILLEGAL = 4'b1111
  } alu_op_e;

  typedef struct packed {
    alu_op_e               op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [4:0]            rd;
    logic                  ill;
  } beat_t;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  beat_t                 dec;
  beat_t                 main_q, main_d;
  beat_t                 skid_q, skid_d;
  logic                  main_vld_q, main_vld_d;
  logic                  skid_vld_q, skid_vld_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  in_xfer, out_xfer;

  // Decode the incoming instruction into the stored beat format.
  always_comb begin
    dec     = '0;
    dec.op  = ALU_ILLEGAL;
    dec.rd  = Rd_i;
    unique case (Opcode_i)
      OPC_R: begin
        if (Funct3_i == 3'b000 && Funct7_i == 7'b0000000) dec.op = ALU_ADD;
        else if (Funct3_i == 3'b000 && Funct7_i == 7'b0100000) dec.op = ALU_SUB;
      end
      OPC_I: begin
        if (Funct3_i == 3'b000) dec.op = ALU_ADD;
        else if (Funct3_i == 3'b110) dec.op = ALU_ORI;
        else if (Funct3_i == 3'b001 && Funct7_i == 7'b0000000) dec.op = ALU_SLLI;
        else if (Funct3_i == 3'b101 && Funct7_i == 7'b0000000) dec.op = ALU_SRLI;
      end
      OPC_LUI:              dec.op = ALU_LUI;
      OPC_LOAD, OPC_STORE:  dec.op = ALU_ADD;
      default:              dec.op = ALU_ILLEGAL;
    endcase
    if (dec.op == ALU_ILLEGAL) begin
      dec.ill = 1'b1;
    end else begin
      dec.a = (dec.op == ALU_LUI) ? '0 : Rs1_Data_i;
      dec.b = (Opcode_i == OPC_R) ? Rs2_Data_i : Imm_i;
    end
  end

  assign in_xfer  = In_Valid_i & ~skid_vld_q;
  assign out_xfer = main_vld_q & Out_Ready_i;

  // Skid invariant: skid only holds a beat while main is full, so whenever
  // main frees up it drains the skid first, and no beat can arrive then
  // (In_Ready_o is low while the skid is full).
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q + {{(CNT_WIDTH-1){1'b0}}, out_xfer};
    if (Flush_i) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || out_xfer) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_xfer) begin
        main_d     = dec;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign In_Ready_o      = ~skid_vld_q;
  assign Out_Valid_o     = main_vld_q;
  assign ALU_Operation_o = main_q.op;
  assign A_o             = main_q.a;
  assign B_o             = main_q.b;
  assign Rd_o            = main_q.rd;
  assign Illegal_o       = main_q.ill;
  assign Issued_Count_o  = cnt_q;

endmodule
